// File: rtl/button_conditioner.sv
// Debounced push-button strobe generator with synchronized data sample.
// Optional auto-repeat while held: define AUTO_REPEAT_EN.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       sw_raw,
    output logic       next_pulse,
    output logic       in_sample,
    output logic       pressed,
    output logic [7:0] press_count,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
        $error("button_conditioner: parameter out of range");
    end

    logic [1:0]  btn_sync;
    logic [1:0]  sw_sync;
    logic        btn_s;
    logic        sw_s;
    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic        strobe;
    logic        pressed_nx;

    assign btn_s     = btn_sync[1];
    assign sw_s      = sw_sync[1];
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync <= '0;
            sw_sync  <= '0;
        end else begin
            btn_sync <= {btn_sync[0], btn_raw};
            sw_sync  <= {sw_sync[0], sw_raw};
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [15:0] RP_LAST = 16'(REPEAT_CYCLES - 1);
    logic [15:0] rep_cnt;
    logic [15:0] rep_nx;
    logic        rep_hit;

    assign rep_hit = (rep_cnt == RP_LAST);

    // Counts only while staying in HELD; any entry or strobe restarts it.
    always_comb begin
        rep_nx = '0;
        if (state == HELD && state_nx == HELD && !strobe) begin
            rep_nx = rep_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_nx;
        end
    end
`else
    logic rep_hit;
    assign rep_hit = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        strobe     = 1'b0;
        pressed_nx = pressed;
        unique case (state)
            RELEASED: begin
                if (btn_s) begin
                    state_nx = PRESS_CHK;
                    cnt_nx   = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_nx = RELEASED;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx   = HELD;
                    cnt_nx     = '0;
                    strobe     = 1'b1;
                    pressed_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nx = RELEASE_CHK;
                    cnt_nx   = '0;
                end else if (rep_hit) begin
                    strobe = 1'b1;
                end
            end
            RELEASE_CHK: begin
                if (btn_s) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx   = RELEASED;
                    cnt_nx     = '0;
                    pressed_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: begin
                state_nx = RELEASED;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RELEASED;
            cnt         <= '0;
            next_pulse  <= 1'b0;
            in_sample   <= 1'b0;
            pressed     <= 1'b0;
            press_count <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            next_pulse <= strobe;
            pressed    <= pressed_nx;
            if (strobe) begin
                in_sample   <= sw_s;
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed checks of button_conditioner against a
// run-length reference model of the debounce and repeat rules.
module tb_button_conditioner;

    localparam int D = 16;
    localparam int R = 64;
`ifdef AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_raw = 1'b0;
    logic       sw_raw = 1'b0;
    logic       next_pulse;
    logic       in_sample;
    logic       pressed;
    logic [7:0] press_count;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int npulse = 0;

    // Reference model: inputs seen two edges late, a level is accepted
    // after D+1 consecutive opposite samples.
    bit bh0, bh1, sh0, sh1;
    bit lvl;
    int run, age, m_cnt, m_state;
    bit m_pulse, m_ins;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .sw_raw(sw_raw),
        .next_pulse(next_pulse),
        .in_sample(in_sample),
        .pressed(pressed),
        .press_count(press_count),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        bh0 = 0; bh1 = 0; sh0 = 0; sh1 = 0;
        lvl = 0; run = 0; age = 0; m_cnt = 0; m_state = 0;
        m_pulse = 0; m_ins = 0;
    endtask

    task automatic fire(input bit s);
        m_pulse = 1;
        m_ins   = s;
        m_cnt   = (m_cnt + 1) % 256;
    endtask

    task automatic model_step();
        bit b, s, was_chk;
        b = bh1; s = sh1;
        bh1 = bh0; bh0 = btn_raw;
        sh1 = sh0; sh0 = sw_raw;
        m_pulse = 0;
        was_chk = (run > 0);
        if (b != lvl) run++;
        else run = 0;
        if (run == D + 1) begin
            lvl = b; run = 0; age = 0;
            if (b) fire(s);
        end else if (lvl && run == 0) begin
            if (was_chk) age = 0;
            else begin
                age++;
                if (REP && age == R) begin
                    age = 0;
                    fire(s);
                end
            end
        end
        m_state = (run == 0) ? (lvl ? 2 : 0) : (lvl ? 3 : 1);
    endtask

    task automatic compare_all();
        check("next_pulse", int'(next_pulse), int'(m_pulse));
        check("in_sample", int'(in_sample), int'(m_ins));
        check("pressed", int'(pressed), int'(lvl));
        check("press_count", int'(press_count), m_cnt);
        check("dbg_state", int'(dbg_state), m_state);
        if (next_pulse) npulse++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int i = 0; i < n; i++) begin
            btn_raw = 1'($urandom);
            sw_raw  = 1'($urandom);
            tick();
        end
        btn_raw = 1'b0;
        sw_raw  = 1'b0;
        reset   = 1'b1;
    endtask

    task automatic wait_first_pulse(output int n);
        n = 0;
        for (int i = 1; i <= 100 && n == 0; i++) begin
            tick();
            if (next_pulse) n = i;
        end
        if (n == 0) check("first_pulse_timeout", 0, 1);
    endtask

    initial begin
        int lat, p0, last;
        int seq[$];
        model_reset();

        // Reset held with toggling inputs
        do_reset(12);

        // Clean press, latency and sampled data
        sw_raw  = 1'b1;
        btn_raw = 1'b1;
        p0 = npulse;
        wait_first_pulse(lat);
        check("latency", lat, D + 3);
        ticks(60 - lat);
        check("single_pulse", npulse - p0, 1);
        check("count_after_press", int'(press_count), 1);
        check("in_sample_one", int'(in_sample), 1);
        check("pressed_high", int'(pressed), 1);
        check("held_state", int'(dbg_state), 2);

        // Release bounce from HELD
        sw_raw = 1'b0;
        seq.delete();
        last = int'(dbg_state);
        btn_raw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) btn_raw = 1'b1;
            if (i == 8) btn_raw = 1'b0;
            tick();
            if (int'(dbg_state) != last) begin
                last = int'(dbg_state);
                seq.push_back(last);
            end
        end
        check("rel_seq_len", seq.size(), 4);
        if (seq.size() == 4) begin
            check("rel_seq0", seq[0], 3);
            check("rel_seq1", seq[1], 2);
            check("rel_seq2", seq[2], 3);
            check("rel_seq3", seq[3], 0);
        end
        check("no_extra_pulse", npulse - p0, 1);
        check("pressed_low", int'(pressed), 0);

        // Short press rejected
        do_reset(3);
        p0 = npulse;
        btn_raw = 1'b1;
        ticks(10);
        btn_raw = 1'b0;
        ticks(30);
        check("short_no_pulse", npulse - p0, 0);
        check("short_count", int'(press_count), 0);
        check("short_state", int'(dbg_state), 0);

        // Long hold: auto-repeat behaviour
        do_reset(3);
        sw_raw  = 1'b1;
        btn_raw = 1'b1;
        p0 = npulse;
        wait_first_pulse(lat);
        sw_raw = 1'b0;
        ticks(200);
        check("hold_pulses", npulse - p0, REP ? 4 : 1);
        check("hold_count", int'(press_count), REP ? 4 : 1);
        btn_raw = 1'b0;
        ticks(30);

        // Reset in PRESS_CHK aborts, then 256 presses wrap the count
        do_reset(3);
        p0 = npulse;
        btn_raw = 1'b1;
        ticks(10);
        do_reset(3);
        check("abort_no_pulse", npulse - p0, 0);
        check("abort_count", int'(press_count), 0);
        for (int k = 0; k < 256; k++) begin
            sw_raw  = 1'($urandom);
            btn_raw = 1'b1;
            ticks(25);
            btn_raw = 1'b0;
            ticks(25);
        end
        check("wrap_pulses", npulse - p0, 256);
        check("wrap_count", int'(press_count), 0);

        // Random bouncy episodes with occasional resets
        for (int e = 0; e < 150; e++) begin
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 4));
            for (int i = 0; i < int'($urandom_range(0, 30)); i++) begin
                btn_raw = 1'($urandom);
                if ($urandom_range(0, 3) == 0) sw_raw = 1'($urandom);
                tick();
            end
            btn_raw = 1'($urandom);
            sw_raw  = 1'($urandom);
            for (int i = 0; i < int'($urandom_range(0, 150)); i++) begin
                if ($urandom_range(0, 9) == 0) sw_raw = 1'($urandom);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter REPEAT_CYCLES, default 64: auto-repeat period in cycles; used only when AUTO_REPEAT_EN is defined; legal range 2..65535.
REQ-003 Port clk, input, 1: single clock; all state SHALL be updated on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; low clears all state immediately.
REQ-005 Port btn_raw, input, 1: asynchronous, bouncing push-button level; high means pressed.
REQ-006 Port sw_raw, input, 1: asynchronous data switch level.
REQ-007 Port next_pulse, output, 1: clean one-cycle strobe per accepted press; drives the downstream accumulator's next input.
REQ-008 Port in_sample, output, 1: synchronized sw_raw value captured with each next_pulse; drives the downstream accumulator's in input.
REQ-009 Port pressed, output, 1: debounced button level.
REQ-010 Port press_count, output, 8: number of next_pulse strobes issued since reset.
REQ-011 Port dbg_state, output, 2: FSM state encoding RELEASED=0, PRESS_CHK=1, HELD=2, RELEASE_CHK=3.

Function
REQ-012 btn_raw and sw_raw SHALL each pass through a two-flop synchronizer before any use; the FSM SHALL act only on the synchronized values btn_s and sw_s.
REQ-013 In RELEASED, btn_s=1 -> PRESS_CHK with the debounce counter at 0.
REQ-014 In PRESS_CHK: btn_s=0 -> RELEASED with the counter cleared; btn_s=1 with counter=DEBOUNCE_CYCLES-1 -> HELD; otherwise the counter increments.
REQ-015 On the PRESS_CHK->HELD edge: next_pulse=1 for exactly one cycle, in_sample<=sw_s on that same edge, pressed<=1, press_count increments.
REQ-016 With btn_raw stable high, next_pulse SHALL first be high in the cycle after rising edge 2+DEBOUNCE_CYCLES+1, counted from the first edge that samples btn_raw=1.
REQ-017 In HELD, btn_s=0 -> RELEASE_CHK with the counter at 0.
REQ-018 In RELEASE_CHK: btn_s=1 -> HELD with no pulse; btn_s=0 with counter=DEBOUNCE_CYCLES-1 -> RELEASED with pressed<=0; otherwise the counter increments.
REQ-019 in_sample SHALL hold its value between strobes; sw_raw changes SHALL NOT affect in_sample except at a strobe.
REQ-020 press_count SHALL wrap from 255 to 0 with no flag.
REQ-021 The block SHALL issue at most one strobe per accepted press; bounce in any state SHALL NOT create additional strobes.

Reset
REQ-022 While reset=0: next_pulse=0, in_sample=0, pressed=0, press_count=0, dbg_state=0, all counters and synchronizer flops=0.
REQ-023 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no strobe; after release, operation restarts from RELEASED.

Configuration
REQ-024 Macro AUTO_REPEAT_EN: when defined, a repeat counter runs while in HELD and issues a further next_pulse every REPEAT_CYCLES cycles after the previous strobe; each repeat strobe resamples in_sample and increments press_count.
REQ-025 AUTO_REPEAT_EN: when defined, the repeat counter clears on leaving HELD, and a RELEASE_CHK->HELD bounce restarts it from 0.
REQ-026 AUTO_REPEAT_EN: when undefined, no repeat logic is present and exactly one strobe is issued per press.

Verification (DEBOUNCE_CYCLES=16, REPEAT_CYCLES=64)
REQ-027 Hold reset low, toggle inputs -> all outputs 0 and dbg_state=0 throughout.
REQ-028 sw_raw=1, then btn_raw high for 60 cycles -> a single next_pulse per REQ-016 with in_sample=1; press_count=1; pressed=1; dbg_state=2.
REQ-029 btn_raw high for 10 cycles then low -> no strobe, press_count=0, dbg_state returns to 0.
REQ-030 From HELD: btn_raw low 5 cycles, high 3, then low stable -> no extra strobe; dbg_state goes 3,2,3, then reaches 0 after 16 stable cycles; pressed=0.
REQ-031 Hold btn_raw 200 cycles past the first strobe -> with AUTO_REPEAT_EN, 3 more strobes at +64, +128 and +192 cycles and press_count=4; without it, press_count=1.
REQ-032 Reset mid PRESS_CHK gives no strobe; 256 clean presses bring press_count back to 0.
